picosoc_a2_mailbox: RTL and testbench

- Bidirectional byte mailbox between the Apple II bus and the PicoSoC.
- Sits beside the A2FPGA PicoSoC peripheral on the same iomem bus. It feeds the firmware command bytes written by the Apple II and returns reply bytes that the Apple II reads.
- Contains two synchronous FIFOs: RX (Apple II to SoC) and TX (SoC to Apple II). Each has status, a sticky overflow flag and a level-sensitive interrupt to the SoC.

---
 rtl/picosoc_a2_mailbox.sv | 240 ++++++++++++++++++++++++
 tb/tb_picosoc_a2_mailbox.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/picosoc_a2_mailbox.sv
// Bidirectional byte mailbox between the Apple II bus and the PicoSoC iomem bus.
// RX carries Apple II command bytes to the firmware; TX carries reply bytes back.

module picosoc_a2_mailbox_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  input  logic       flush,
  input  logic       clr_ovf,
  output logic [7:0] head,
  output logic [8:0] count,
  output logic       empty,
  output logic       full,
  output logic       ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  // A flush in the same cycle as a push discards the pushed byte as well.
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
    if (clr_ovf)     ovf_d = 1'b0;
    if (push & full) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = 9'(count_q);
  assign ovf   = ovf_q;
endmodule

module picosoc_a2_mailbox #(
  parameter int SLOT  = 4,
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        iomem_ready,
  input  logic [15:0] a2_addr,
  input  logic        a2_rw_n,
  input  logic        a2_data_in_strobe,
  input  logic [7:0]  a2_data,
  output logic [7:0]  a2_rd_data_o,
  output logic        a2_rd_en_o,
  output logic        irq_o
);
  localparam logic [15:0] BASE = 16'hC080 + 16'(SLOT * 16);

  localparam logic [5:0] REG_RX_DATA   = 6'h00;
  localparam logic [5:0] REG_RX_STATUS = 6'h01;
  localparam logic [5:0] REG_TX_DATA   = 6'h02;
  localparam logic [5:0] REG_TX_STATUS = 6'h03;
  localparam logic [5:0] REG_CONTROL   = 6'h04;

  logic [31:0] iomem_rdata_q, iomem_rdata_d;
  logic        iomem_ready_q, iomem_ready_d;
  logic [1:0]  irq_en_q, irq_en_d;
  logic        irq_q, irq_d;

  logic        a2_hit_data, a2_hit_status;
  logic        a2_push_rx, a2_pop_tx, a2_clr_rx, a2_clr_tx;
  logic        soc_acc, soc_wr;
  logic [5:0]  soc_sel;
  logic        soc_pop_rx, soc_push_tx, soc_clr_rx, soc_clr_tx;
  logic        flush_rx, flush_tx;

  logic [7:0]  rx_head, tx_head;
  logic [8:0]  rx_count, tx_count;
  logic        rx_empty, rx_full, rx_ovf;
  logic        tx_empty, tx_full, tx_ovf;
  logic [7:0]  a2_status;

  logic        unused_ok;

  assign a2_hit_data   = (a2_addr == BASE);
  assign a2_hit_status = (a2_addr == BASE + 16'd1);
  assign a2_push_rx    = a2_data_in_strobe & ~a2_rw_n & a2_hit_data;
  assign a2_pop_tx     = a2_data_in_strobe &  a2_rw_n & a2_hit_data;
  assign a2_clr_rx     = a2_data_in_strobe & ~a2_rw_n & a2_hit_status & a2_data[0];
  assign a2_clr_tx     = a2_data_in_strobe & ~a2_rw_n & a2_hit_status & a2_data[1];

  assign a2_status  = {~tx_empty, rx_full, rx_ovf, tx_ovf, 4'b0000};
  assign a2_rd_en_o = a2_rw_n & (a2_hit_data | a2_hit_status);

  always_comb begin
    a2_rd_data_o = 8'h00;
    if (a2_hit_data)        a2_rd_data_o = tx_empty ? 8'hFF : tx_head;
    else if (a2_hit_status) a2_rd_data_o = a2_status;
  end

  // An access is taken only while ready is low, so a held request is served once.
  assign soc_acc = iomem_valid & ~iomem_ready_q;
  assign soc_wr  = |iomem_wstrb;
  assign soc_sel = iomem_addr[7:2];

  always_comb begin
    soc_pop_rx    = 1'b0;
    soc_push_tx   = 1'b0;
    soc_clr_rx    = 1'b0;
    soc_clr_tx    = 1'b0;
    flush_rx      = 1'b0;
    flush_tx      = 1'b0;
    irq_en_d      = irq_en_q;
    iomem_ready_d = soc_acc;
    iomem_rdata_d = 32'h0;
    if (soc_acc) begin
      case (soc_sel)
        REG_RX_DATA: begin
          if (!soc_wr && !rx_empty) begin
            iomem_rdata_d = {23'b0, 1'b1, rx_head};
            soc_pop_rx    = 1'b1;
          end
        end
        REG_RX_STATUS: begin
          if (soc_wr) soc_clr_rx = iomem_wdata[31];
          else        iomem_rdata_d = {rx_ovf, 22'b0, rx_count};
        end
        REG_TX_DATA: begin
          if (soc_wr) soc_push_tx = 1'b1;
        end
        REG_TX_STATUS: begin
          if (soc_wr) soc_clr_tx = iomem_wdata[31];
          else        iomem_rdata_d = {tx_ovf, 22'b0, tx_count};
        end
        REG_CONTROL: begin
          if (soc_wr) begin
            irq_en_d = iomem_wdata[1:0];
            flush_rx = iomem_wdata[8];
            flush_tx = iomem_wdata[9];
          end else begin
            iomem_rdata_d = {30'b0, irq_en_q};
          end
        end
        default: ;
      endcase
    end
  end

  assign irq_d = (irq_en_q[0] & ~rx_empty) | (irq_en_q[1] & (rx_ovf | tx_ovf));

  always_ff @(posedge clk) begin
    if (reset) begin
      iomem_rdata_q <= 32'h0;
      iomem_ready_q <= 1'b0;
      irq_en_q      <= 2'b00;
      irq_q         <= 1'b0;
    end else begin
      iomem_rdata_q <= iomem_rdata_d;
      iomem_ready_q <= iomem_ready_d;
      irq_en_q      <= irq_en_d;
      irq_q         <= irq_d;
    end
  end

  picosoc_a2_mailbox_fifo #(.DEPTH(DEPTH)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .push      (a2_push_rx),
    .push_data (a2_data),
    .pop       (soc_pop_rx),
    .flush     (flush_rx),
    .clr_ovf   (soc_clr_rx | a2_clr_rx),
    .head      (rx_head),
    .count     (rx_count),
    .empty     (rx_empty),
    .full      (rx_full),
    .ovf       (rx_ovf)
  );

  picosoc_a2_mailbox_fifo #(.DEPTH(DEPTH)) u_tx (
    .clk       (clk),
    .reset     (reset),
    .push      (soc_push_tx),
    .push_data (iomem_wdata[7:0]),
    .pop       (a2_pop_tx),
    .flush     (flush_tx),
    .clr_ovf   (soc_clr_tx | a2_clr_tx),
    .head      (tx_head),
    .count     (tx_count),
    .empty     (tx_empty),
    .full      (tx_full),
    .ovf       (tx_ovf)
  );

  assign iomem_rdata = iomem_rdata_q;
  assign iomem_ready = iomem_ready_q;
  assign irq_o       = irq_q;

  assign unused_ok = ^{iomem_addr[31:8], iomem_addr[1:0], iomem_wdata[30:10], tx_full};
endmodule

// File: tb/tb_picosoc_a2_mailbox.sv
// Directed and randomized checks of picosoc_a2_mailbox against a queue-based
// model of the two mailboxes, their flags and the interrupt enables.

module tb_picosoc_a2_mailbox;
  localparam int          DEPTH = 16;
  localparam logic [15:0] BASE  = 16'hC0C0;

  logic        clk = 1'b0;
  logic        reset;
  logic        iomem_valid;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        iomem_ready;
  logic [15:0] a2_addr;
  logic        a2_rw_n;
  logic        a2_data_in_strobe;
  logic [7:0]  a2_data;
  logic [7:0]  a2_rd_data_o;
  logic        a2_rd_en_o;
  logic        irq_o;

  always #5 clk = ~clk;

  picosoc_a2_mailbox #(.SLOT(4), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .iomem_valid       (iomem_valid),
    .iomem_wstrb       (iomem_wstrb),
    .iomem_addr        (iomem_addr),
    .iomem_wdata       (iomem_wdata),
    .iomem_rdata       (iomem_rdata),
    .iomem_ready       (iomem_ready),
    .a2_addr           (a2_addr),
    .a2_rw_n           (a2_rw_n),
    .a2_data_in_strobe (a2_data_in_strobe),
    .a2_data           (a2_data),
    .a2_rd_data_o      (a2_rd_data_o),
    .a2_rd_en_o        (a2_rd_en_o),
    .irq_o             (irq_o)
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic       rx_ovf, tx_ovf;
  logic [1:0] irq_en;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_a2_status();
    return {(tx_q.size() != 0), (rx_q.size() == DEPTH), rx_ovf, tx_ovf, 4'b0000};
  endfunction

  function automatic logic model_irq();
    return (irq_en[0] && rx_q.size() != 0) || (irq_en[1] && (rx_ovf || tx_ovf));
  endfunction

  function automatic void model_rx_push(input logic [7:0] d);
    if (rx_q.size() < DEPTH) rx_q.push_back(d);
    else rx_ovf = 1'b1;
  endfunction

  function automatic void model_tx_push(input logic [7:0] d);
    if (tx_q.size() < DEPTH) tx_q.push_back(d);
    else tx_ovf = 1'b1;
  endfunction

  function automatic void model_clear();
    rx_q.delete();
    tx_q.delete();
    rx_ovf = 1'b0;
    tx_ovf = 1'b0;
    irq_en = 2'b00;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    a2_data_in_strobe = 1'b0;
    a2_rw_n = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_clear();
    checkOutput("reset_ready", 32'(iomem_ready), 32'd0);
    checkOutput("reset_rdata", iomem_rdata, 32'd0);
    checkOutput("reset_irq", 32'(irq_o), 32'd0);
  endtask

  task automatic check_irq();
    @(posedge clk);
    #1;
    checkOutput("irq", 32'(irq_o), 32'(model_irq()));
  endtask

  task automatic a2_write(input logic [15:0] addr, input logic [7:0] data);
    @(negedge clk);
    a2_addr = addr;
    a2_rw_n = 1'b0;
    a2_data = data;
    a2_data_in_strobe = 1'b1;
    #1;
    checkOutput("a2_wr_rd_en", 32'(a2_rd_en_o), 32'd0);
    @(negedge clk);
    a2_data_in_strobe = 1'b0;
    a2_rw_n = 1'b1;
    if (addr == BASE) model_rx_push(data);
    else if (addr == BASE + 16'd1) begin
      if (data[0]) rx_ovf = 1'b0;
      if (data[1]) tx_ovf = 1'b0;
    end
  endtask

  task automatic a2_read(input logic [15:0] addr);
    logic [7:0] exp;
    @(negedge clk);
    a2_addr = addr;
    a2_rw_n = 1'b1;
    a2_data_in_strobe = 1'b1;
    #1;
    checkOutput("a2_rd_en", 32'(a2_rd_en_o), 32'(addr == BASE || addr == BASE + 16'd1));
    if (addr == BASE) begin
      exp = (tx_q.size() == 0) ? 8'hFF : tx_q[0];
      checkOutput("a2_rd_data", 32'(a2_rd_data_o), 32'(exp));
      if (tx_q.size() != 0) void'(tx_q.pop_front());
    end else if (addr == BASE + 16'd1) begin
      checkOutput("a2_status", 32'(a2_rd_data_o), 32'(model_a2_status()));
    end
    @(negedge clk);
    a2_data_in_strobe = 1'b0;
  endtask

  task automatic drive_soc(input logic [7:0] off, input logic [3:0] wstrb, input logic [31:0] wdata);
    logic [31:0] r;
    r = $urandom();
    iomem_valid = 1'b1;
    iomem_wstrb = wstrb;
    iomem_wdata = wdata;
    iomem_addr  = {r[31:8], off[7:2], r[1:0]};
  endtask

  task automatic soc_access(input logic [7:0] off, input logic [3:0] wstrb, input logic [31:0] wdata,
                            output logic [31:0] rdata);
    int cycles;
    @(negedge clk);
    drive_soc(off, wstrb, wdata);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (!iomem_ready && cycles < 8);
    checkOutput("soc_latency", 32'(cycles), 32'd1);
    rdata = iomem_rdata;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    @(posedge clk);
    #1;
    checkOutput("soc_ready_pulse", 32'(iomem_ready), 32'd0);
    checkOutput("soc_rdata_idle", iomem_rdata, 32'd0);
  endtask

  task automatic soc_read(input logic [7:0] off);
    logic [31:0] exp, got;
    exp = 32'h0;
    case (off)
      8'h00: if (rx_q.size() != 0) exp = {23'b0, 1'b1, rx_q.pop_front()};
      8'h04: exp = {rx_ovf, 22'b0, 9'(rx_q.size())};
      8'h0C: exp = {tx_ovf, 22'b0, 9'(tx_q.size())};
      8'h10: exp = {30'b0, irq_en};
      default: exp = 32'h0;
    endcase
    soc_access(off, 4'h0, 32'(int'($urandom())), got);
    checkOutput($sformatf("soc_rd_%02h", off), got, exp);
  endtask

  task automatic soc_write(input logic [7:0] off, input logic [31:0] wdata);
    logic [31:0] got;
    soc_access(off, 4'($urandom_range(1, 15)), wdata, got);
    case (off)
      8'h04: if (wdata[31]) rx_ovf = 1'b0;
      8'h08: model_tx_push(wdata[7:0]);
      8'h0C: if (wdata[31]) tx_ovf = 1'b0;
      8'h10: begin
        irq_en = wdata[1:0];
        if (wdata[8]) rx_q.delete();
        if (wdata[9]) tx_q.delete();
      end
      default: ;
    endcase
  endtask

  // Apple II write strobe and a SoC access presented on the same clock edge.
  task automatic concurrent(input logic [15:0] a2a, input logic [7:0] a2d, input logic [7:0] off,
                            input logic [3:0] wstrb, input logic [31:0] wdata, output logic [31:0] rdata);
    @(negedge clk);
    a2_addr = a2a;
    a2_rw_n = 1'b0;
    a2_data = a2d;
    a2_data_in_strobe = 1'b1;
    drive_soc(off, wstrb, wdata);
    @(posedge clk);
    #1;
    checkOutput("conc_ready", 32'(iomem_ready), 32'd1);
    rdata = iomem_rdata;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    @(negedge clk);
    a2_data_in_strobe = 1'b0;
    a2_rw_n = 1'b1;
  endtask

  task automatic applyStimulus();
    logic [15:0] a;
    case ($urandom_range(0, 13))
      0, 1:  a2_write(BASE, 8'($urandom()));
      2:     a2_read(BASE);
      3:     a2_read(BASE + 16'd1);
      4:     a2_write(BASE + 16'd1, 8'($urandom_range(0, 3)));
      5:     soc_read(8'h00);
      6:     soc_read(8'h04);
      7, 8:  soc_write(8'h08, 32'($urandom()));
      9:     soc_read(8'h0C);
      10:    soc_write(($urandom_range(0, 1) != 0) ? 8'h04 : 8'h0C, {1'($urandom()), 31'($urandom())});
      11:    soc_write(8'h10, {22'b0, ($urandom_range(0, 7) == 0) ? 2'($urandom()) : 2'b00,
                               6'b0, 2'($urandom())});
      12: begin
        if ($urandom_range(0, 1) != 0) soc_read(8'(8'h14 + 4 * $urandom_range(0, 10)));
        else soc_write(8'(8'h14 + 4 * $urandom_range(0, 10)), 32'hFFFF_FFFF);
      end
      default: begin
        a = 16'($urandom());
        if (a == BASE || a == BASE + 16'd1) a = BASE + 16'd2;
        if ($urandom_range(0, 1) != 0) a2_read(a);
        else a2_write(a, 8'($urandom()));
      end
    endcase
    if ($urandom_range(0, 3) == 0) check_irq();
  endtask

  initial begin
    logic [31:0] got;
    reset = 1'b1;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    iomem_addr  = 32'h0;
    iomem_wdata = 32'h0;
    a2_addr = 16'h0;
    a2_rw_n = 1'b1;
    a2_data_in_strobe = 1'b0;
    a2_data = 8'h0;

    $display("[TB] reset state");
    do_reset();
    soc_read(8'h04);
    soc_read(8'h0C);
    soc_read(8'h00);
    a2_read(BASE);
    a2_read(BASE + 16'd1);
    check_irq();

    $display("[TB] basic RX path");
    a2_write(BASE, 8'h41);
    a2_write(BASE, 8'h42);
    soc_read(8'h04);
    soc_read(8'h00);
    soc_read(8'h00);
    soc_read(8'h00);

    $display("[TB] RX nonempty interrupt");
    soc_write(8'h10, 32'h1);
    soc_read(8'h10);
    a2_write(BASE, 8'h55);
    checkOutput("irq_lags_push", 32'(irq_o), 32'd0);
    check_irq();
    soc_read(8'h00);
    check_irq();
    soc_write(8'h10, 32'h0);

    $display("[TB] RX overflow");
    for (int i = 0; i < 17; i++) a2_write(BASE, 8'(8'h60 + i));
    soc_read(8'h04);
    a2_read(BASE + 16'd1);
    soc_write(8'h10, 32'h2);
    check_irq();
    a2_write(BASE + 16'd1, 8'h01);
    a2_read(BASE + 16'd1);
    check_irq();
    for (int i = 0; i < 17; i++) soc_read(8'h00);

    $display("[TB] TX path");
    soc_write(8'h08, 32'hAA);
    soc_write(8'h08, 32'h1BB);
    a2_read(BASE + 16'd1);
    a2_read(BASE);
    a2_read(BASE);
    a2_read(BASE + 16'd1);
    a2_read(BASE);

    $display("[TB] simultaneous RX push and pop");
    a2_write(BASE, 8'h11);
    a2_write(BASE, 8'h22);
    a2_write(BASE, 8'h33);
    concurrent(BASE, 8'h44, 8'h00, 4'h0, 32'h0, got);
    checkOutput("conc_pop", got, {23'b0, 1'b1, 8'h11});
    void'(rx_q.pop_front());
    model_rx_push(8'h44);
    soc_read(8'h04);
    for (int i = 0; i < 3; i++) soc_read(8'h00);

    $display("[TB] flush with simultaneous push");
    a2_write(BASE, 8'h01);
    a2_write(BASE, 8'h02);
    concurrent(BASE, 8'h03, 8'h10, 4'hF, 32'h100, got);
    rx_q.delete();
    irq_en = 2'b00;
    soc_read(8'h04);
    soc_read(8'h00);
    soc_write(8'h08, 32'h5A);
    soc_write(8'h08, 32'h5B);
    soc_write(8'h10, 32'h200);
    a2_read(BASE);
    soc_read(8'h0C);

    $display("[TB] overflow set beats clear");
    for (int i = 0; i < DEPTH; i++) a2_write(BASE, 8'(i));
    concurrent(BASE, 8'hEE, 8'h04, 4'hF, 32'h8000_0000, got);
    rx_ovf = 1'b1;
    soc_read(8'h04);
    a2_read(BASE + 16'd1);

    $display("[TB] reset mid-operation");
    soc_write(8'h08, 32'h77);
    soc_write(8'h10, 32'h3);
    do_reset();
    soc_read(8'h04);
    soc_read(8'h0C);
    soc_read(8'h10);
    a2_read(BASE);
    check_irq();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) applyStimulus();
    while (rx_q.size() != 0) soc_read(8'h00);
    while (tx_q.size() != 0) a2_read(BASE);
    soc_read(8'h04);
    a2_read(BASE + 16'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
